uart_tx_frame: RTL

UART transmit framer: the transmit-side counterpart of the receiver's parity checker and deserializer. Accepts one byte per handshake and serializes it LSB first. The frame is start bit (0), 8 data bits, an optional parity bit (even/odd) and a stop bit (1). Each bit lasts a parameterized number of clock cycles. Sits between the TX data source (FIFO/CPU side) and the serial line pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_frame_if.sv | 33 +++
 rtl/uart_parity_gen.sv | 20 ++
 rtl/uart_tx_frame.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit framer and the receive-side
// checker: the framer state encoding, parity-type codes and line levels for
// the start and stop bits.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic EVEN_PARITY = 1'b0;
  localparam logic ODD_PARITY  = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_if
// Groups the byte handshake from the TX data source and the serial-side
// outputs of the framer.
//   P_Data       byte to transmit
//   Data_Valid   request to send P_Data
//   Par_en       1 = append a parity bit
//   Parity_Type  0 = even, 1 = odd
//   TX_OUT       serial line (idle high)
//   Busy         high while a frame is in flight
// master: the data source (drives the request, observes line and Busy)
// slave : the framer
// ---------------------------------------------------------------------------
interface uart_tx_frame_if;

  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Par_en;
  logic       Parity_Type;
  logic       TX_OUT;
  logic       Busy;

  modport master (
    output P_Data, Data_Valid, Par_en, Parity_Type,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_Data, Data_Valid, Par_en, Parity_Type,
    output TX_OUT, Busy
  );

endinterface : uart_tx_frame_if

// File: rtl/uart_parity_gen.sv
// ---------------------------------------------------------------------------
// uart_parity_gen
// Combinational parity for one byte. The same block sits in the receive
// checker, so both ends agree on what "even" and "odd" mean.
//   data         byte to protect
//   parity_type  EVEN_PARITY / ODD_PARITY
//   parity       bit that makes the total count of ones even (or odd)
// ---------------------------------------------------------------------------
module uart_parity_gen
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  logic       parity_type,
  output logic       parity
);

  // Even: XOR of the data. Odd: its complement.
  assign parity = (parity_type == ODD_PARITY) ? ~^data : ^data;

endmodule : uart_parity_gen

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// UART transmit framer. Accepts one byte per handshake while idle and sends
// start bit, 8 data bits LSB first, optional parity bit and stop bit, each
// held for CLKS_PER_BIT clocks. Requests arriving while a frame is in flight
// are dropped.
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    framer side of uart_tx_frame_if (byte handshake in, line out)
// ---------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 16,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_frame_if.slave     bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       idx, idx_next;
  logic [7:0]       data_q;
  logic             par_en_q;
  logic             parity_q;
  logic             tx_q, tx_next;
  logic             busy_q, busy_next;
  logic             accept;
  logic             bit_done;
  logic             parity_calc;

  uart_parity_gen u_parity_gen (
    .data        (bus.P_Data),
    .parity_type (bus.Parity_Type),
    .parity      (parity_calc)
  );

  assign bit_done = (cnt == CNT_MAX);

  // Next-state, counter/index and the next line level. TX_OUT and Busy are
  // registered from the next state so they change on the same edge as the
  // state, giving the 1-cycle accept latency with glitch-free outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    accept     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.Data_Valid) begin
          accept     = 1'b1;
          state_next = START;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          cnt_next   = '0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next = '0;
          if (idx == 3'd7) begin
            state_next = par_en_q ? PARITY : STOP;
          end else begin
            idx_next = idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase

    unique case (state_next)
      START:   tx_next = START_BIT;
      DATA:    tx_next = data_q[idx_next];
      PARITY:  tx_next = parity_q;
      default: tx_next = STOP_BIT;   // IDLE and STOP both drive the line high
    endcase

    busy_next = (state_next != IDLE);
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= STOP_BIT;
      busy_q   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      idx    <= idx_next;
      tx_q   <= tx_next;
      busy_q <= busy_next;
      // The request fields are captured only on accept; later changes on
      // the inputs do not disturb the frame in flight.
      if (accept) begin
        data_q   <= bus.P_Data;
        par_en_q <= bus.Par_en;
        parity_q <= parity_calc;
      end
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule : uart_tx_frame
